// File: rtl/imm_gen_pkg.sv
// Shared types and opcode/field constants for the LEGv8 immediate generator.
// IMM_GEN_ILLEGAL_EN adds FMT_ILLEGAL for opcodes that match no format.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_D    = 3'd2,
    FMT_B    = 3'd3,
    FMT_CB   = 3'd4,
    FMT_IM   = 3'd5
`ifdef IMM_GEN_ILLEGAL_EN
    , FMT_ILLEGAL = 3'd6
`endif
  } fmt_e;

  // B format, inst[31:26]
  localparam logic [5:0]  OP_B      = 6'b000101;
  localparam logic [5:0]  OP_BL     = 6'b100101;
  // CB format, inst[31:24]
  localparam logic [7:0]  OP_CBZ    = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ   = 8'b10110101;
  localparam logic [7:0]  OP_BCOND  = 8'b01010100;
  // IM format, inst[31:23]
  localparam logic [8:0]  OP_MOVZ   = 9'b110100101;
  localparam logic [8:0]  OP_MOVK   = 9'b111100101;
  // D format, inst[31:21]
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  // I format, inst[31:22]
  localparam logic [9:0]  OP_ADDI   = 10'b1001000100;
  localparam logic [9:0]  OP_ADDIS  = 10'b1011000100;
  localparam logic [9:0]  OP_SUBI   = 10'b1101000100;
  localparam logic [9:0]  OP_SUBIS  = 10'b1111000100;
  localparam logic [9:0]  OP_ANDI   = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI   = 10'b1011001000;
  localparam logic [9:0]  OP_EORI   = 10'b1101001000;
  localparam logic [9:0]  OP_ANDIS  = 10'b1111001000;

  // Immediate field positions
  localparam int B_HI   = 25;
  localparam int B_LO   = 0;
  localparam int B_W    = B_HI - B_LO + 1;
  localparam int CB_HI  = 23;
  localparam int CB_LO  = 5;
  localparam int CB_W   = CB_HI - CB_LO + 1;
  localparam int IM_HI  = 20;
  localparam int IM_LO  = 5;
  localparam int IM_W   = IM_HI - IM_LO + 1;
  localparam int HW_HI  = 22;
  localparam int HW_LO  = 21;
  localparam int D_HI   = 20;
  localparam int D_LO   = 12;
  localparam int D_W    = D_HI - D_LO + 1;
  localparam int I_HI   = 21;
  localparam int I_LO   = 10;
  localparam int I_W    = I_HI - I_LO + 1;

endpackage

// File: rtl/imm_gen_pipe_imm_decode.sv
// Combinational LEGv8 immediate decode: inst -> {imm, fmt}, first match wins.
// IMM_GEN_ILLEGAL_EN: unmatched opcodes report FMT_ILLEGAL instead of FMT_NONE.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int BRANCH_SHIFT = 1
) (
  input  logic [31:0]       inst,
  output logic [DATA_W-1:0] imm,
  output fmt_e              fmt
);

  logic [DATA_W-1:0] b_sx, cb_sx, d_sx, i_zx, im_zx;
  logic [1:0]        hw;

  assign b_sx  = {{(DATA_W-B_W){inst[B_HI]}}, inst[B_HI:B_LO]};
  assign cb_sx = {{(DATA_W-CB_W){inst[CB_HI]}}, inst[CB_HI:CB_LO]};
  assign d_sx  = {{(DATA_W-D_W){inst[D_HI]}}, inst[D_HI:D_LO]};
  assign i_zx  = {{(DATA_W-I_W){1'b0}}, inst[I_HI:I_LO]};
  assign hw    = inst[HW_HI:HW_LO];
  // Shifting inside DATA_W drops halfwords that land above the result width
  assign im_zx = {{(DATA_W-IM_W){1'b0}}, inst[IM_HI:IM_LO]} << {hw, 4'b0000};

  always_comb begin
    imm = '0;
`ifdef IMM_GEN_ILLEGAL_EN
    fmt = FMT_ILLEGAL;
`else
    fmt = FMT_NONE;
`endif
    if (inst[31:26] == OP_B || inst[31:26] == OP_BL) begin
      fmt = FMT_B;
      imm = (BRANCH_SHIFT != 0) ? (b_sx << 2) : b_sx;
    end else if (inst[31:24] == OP_CBZ || inst[31:24] == OP_CBNZ ||
                 inst[31:24] == OP_BCOND) begin
      fmt = FMT_CB;
      imm = (BRANCH_SHIFT != 0) ? (cb_sx << 2) : cb_sx;
    end else if (inst[31:23] == OP_MOVZ || inst[31:23] == OP_MOVK) begin
      fmt = FMT_IM;
      imm = im_zx;
    end else if (inst[31:21] == OP_LDUR || inst[31:21] == OP_STUR) begin
      fmt = FMT_D;
      imm = d_sx;
    end else if (inst[31:22] == OP_ADDI  || inst[31:22] == OP_ADDIS ||
                 inst[31:22] == OP_SUBI  || inst[31:22] == OP_SUBIS ||
                 inst[31:22] == OP_ANDI  || inst[31:22] == OP_ORRI  ||
                 inst[31:22] == OP_EORI  || inst[31:22] == OP_ANDIS) begin
      fmt = FMT_I;
      imm = i_zx;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered LEGv8 immediate generator: decode at the input, 2-entry skid buffer to ID/EX.
// IMM_GEN_ILLEGAL_EN adds out_illegal, set while an unmatched opcode is at the head.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int TAG_W        = 64,
  parameter int BRANCH_SHIFT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_fmt,
  output logic [TAG_W-1:0]  out_tag
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic              out_illegal
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    fmt_e              fmt;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  localparam ent_t ENT_RST = '{imm: '0, fmt: FMT_NONE, tag: '0};

  logic [DATA_W-1:0] dec_imm;
  fmt_e              dec_fmt;
  ent_t              new_ent, head_q, tail_q;
  logic [1:0]        count_q;
  logic              push, pop;

  imm_decode #(
    .DATA_W      (DATA_W),
    .BRANCH_SHIFT(BRANCH_SHIFT)
  ) u_dec (
    .inst(in_inst),
    .imm (dec_imm),
    .fmt (dec_fmt)
  );

  assign new_ent   = '{imm: dec_imm, fmt: dec_fmt, tag: in_tag};
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // head_q is always the oldest entry; tail_q only meaningful when count_q==2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= ENT_RST;
      tail_q  <= ENT_RST;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= new_ent;
          else                 tail_q <= new_ent;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= new_ent;
          end else begin
            head_q <= tail_q;
            tail_q <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_imm = head_q.imm;
  assign out_fmt = head_q.fmt;
  assign out_tag = head_q.tag;

`ifdef IMM_GEN_ILLEGAL_EN
  assign out_illegal = out_valid && (head_q.fmt == FMT_ILLEGAL);
`endif

endmodule
